ex_mem_reg: RTL and testbench

Pipeline register between the execute stage and the memory-access stage of the 5-stage integer core. It captures the execute results at each rising clock edge: register write-back request, HI/LO write request, and the intermediate product of two-cycle multiply-accumulate operations (madd/msub). It also implements stall, bubble-insertion and flush control, so the memory stage only ever sees a committed instruction or a clean NOP.

---
 rtl/ex_mem_reg_pkg.sv | 6 +
 rtl/ex_mem_reg_if.sv | 42 ++++
 rtl/ex_mem_reg_pipe_reg.sv | 29 ++
 rtl/ex_mem_reg.sv | 64 ++++++
 tb/tb_ex_mem_reg.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_reg_pkg.sv
// Shared widths for the EX/MEM pipeline register slice.
package ex_mem_reg_pkg;
    localparam int unsigned DEF_DW = 32;
    localparam int unsigned DEF_AW = 5;
    localparam int unsigned CNT_W  = 2;
endpackage

// File: rtl/ex_mem_reg_if.sv
// Execute-to-memory bus: execute results, stall/flush control and madd feedback.
interface ex_mem_reg_if
    import ex_mem_reg_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned AW = DEF_AW
);
    logic              stall_ex;
    logic              stall_mem;
    logic              flush;
    logic              ex_wreg;
    logic [AW-1:0]     ex_wd;
    logic [DW-1:0]     ex_wdata;
    logic              ex_whilo;
    logic [DW-1:0]     ex_hi;
    logic [DW-1:0]     ex_lo;
    logic [2*DW-1:0]   ex_hilo_tmp;
    logic [CNT_W-1:0]  ex_cnt;
    logic              mem_wreg;
    logic [AW-1:0]     mem_wd;
    logic [DW-1:0]     mem_wdata;
    logic              mem_whilo;
    logic [DW-1:0]     mem_hi;
    logic [DW-1:0]     mem_lo;
    logic              mem_valid;
    logic [2*DW-1:0]   hilo_tmp_o;
    logic [CNT_W-1:0]  cnt_o;

    modport master (
        output stall_ex, stall_mem, flush,
        output ex_wreg, ex_wd, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_hilo_tmp, ex_cnt,
        input  mem_wreg, mem_wd, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_valid,
        input  hilo_tmp_o, cnt_o
    );

    modport slave (
        input  stall_ex, stall_mem, flush,
        input  ex_wreg, ex_wd, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_hilo_tmp, ex_cnt,
        output mem_wreg, mem_wd, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_valid,
        output hilo_tmp_o, cnt_o
    );
endinterface

// File: rtl/ex_mem_reg_pipe_reg.sv
// Width-W register with synchronous reset, clear (to zero) and load enable.
module ex_mem_reg_pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (rst || clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with flush, bubble insertion, hold and madd/msub feedback.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned AW = DEF_AW
) (
    input  logic         clk,
    input  logic         rst,
    ex_mem_reg_if.slave  bus
);
    localparam int unsigned PAY_W = 1 + 1 + AW + DW + 1 + DW + DW;
    localparam int unsigned FB_W  = 2 * DW + CNT_W;

    logic             bubble_c;
    logic             advance_c;
    logic             pay_clr_c;
    logic             fb_clr_c;
    logic [PAY_W-1:0] pay_d_c;
    logic [PAY_W-1:0] pay_q;
    logic [FB_W-1:0]  fb_d_c;
    logic [FB_W-1:0]  fb_q;

    // stall_ex=0 with stall_mem=1 is never produced upstream; it falls through to hold.
    always_comb begin
        bubble_c  = 1'b0;
        advance_c = 1'b0;
        if (bus.stall_ex && !bus.stall_mem) begin
            bubble_c = 1'b1;
        end else if (!bus.stall_ex && !bus.stall_mem) begin
            advance_c = 1'b1;
        end
    end

    // Payload is zeroed (NOP) on flush/bubble; feedback is zeroed once the op completes.
    assign pay_clr_c = bus.flush | bubble_c;
    assign fb_clr_c  = bus.flush | advance_c;

    assign pay_d_c = {1'b1, bus.ex_wreg, bus.ex_wd, bus.ex_wdata,
                      bus.ex_whilo, bus.ex_hi, bus.ex_lo};
    assign fb_d_c  = {bus.ex_hilo_tmp, bus.ex_cnt};

    ex_mem_reg_pipe_reg #(.W(PAY_W)) u_payload (
        .clk (clk),
        .rst (rst),
        .clr (pay_clr_c),
        .en  (advance_c),
        .d   (pay_d_c),
        .q   (pay_q)
    );

    ex_mem_reg_pipe_reg #(.W(FB_W)) u_feedback (
        .clk (clk),
        .rst (rst),
        .clr (fb_clr_c),
        .en  (bubble_c),
        .d   (fb_d_c),
        .q   (fb_q)
    );

    assign {bus.mem_valid, bus.mem_wreg, bus.mem_wd, bus.mem_wdata,
            bus.mem_whilo, bus.mem_hi, bus.mem_lo} = pay_q;
    assign {bus.hilo_tmp_o, bus.cnt_o} = fb_q;
endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed vector table then randomized traffic vs. a model.
module tb_ex_mem_reg;
    import ex_mem_reg_pkg::*;

    typedef struct packed {
        logic        rst, flush, stall_ex, stall_mem, wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi, lo;
        logic [63:0] tmp;
        logic [1:0]  cnt;
    } in_t;

    typedef struct packed {
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi, lo;
        logic        valid;
        logic [63:0] tmp;
        logic [1:0]  cnt;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    ex_mem_reg_if #(.DW(32), .AW(5)) bus ();

    ex_mem_reg #(.DW(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // The stall controller must never request stall_mem without stall_ex.
    always @(posedge clk) begin
        assert (!(!bus.stall_ex && bus.stall_mem))
            else $error("illegal stall combination stall_ex=0 stall_mem=1");
    end

    function automatic in_t mk_in(logic r, logic f, logic se, logic sm, logic wreg,
                                  logic [4:0] wd, logic [31:0] wdata, logic whilo,
                                  logic [31:0] hi, logic [31:0] lo,
                                  logic [63:0] tmp, logic [1:0] cnt);
        return '{rst: r, flush: f, stall_ex: se, stall_mem: sm, wreg: wreg, wd: wd,
                 wdata: wdata, whilo: whilo, hi: hi, lo: lo, tmp: tmp, cnt: cnt};
    endfunction

    function automatic out_t mk_out(logic wreg, logic [4:0] wd, logic [31:0] wdata,
                                    logic whilo, logic [31:0] hi, logic [31:0] lo,
                                    logic valid, logic [63:0] tmp, logic [1:0] cnt);
        return '{wreg: wreg, wd: wd, wdata: wdata, whilo: whilo, hi: hi, lo: lo,
                 valid: valid, tmp: tmp, cnt: cnt};
    endfunction

    // Reference behaviour: one clock edge applied to the visible state.
    function automatic out_t model(in_t i, out_t s);
        out_t n;
        n = s;
        if (i.rst || i.flush) begin
            n = '0;
        end else if (i.stall_ex && !i.stall_mem) begin
            n = '0;
            n.tmp = i.tmp;
            n.cnt = i.cnt;
        end else if (!i.stall_ex) begin
            n = mk_out(i.wreg, i.wd, i.wdata, i.whilo, i.hi, i.lo, 1'b1, 64'h0, 2'b00);
        end
        return n;
    endfunction

    task automatic drive(in_t i);
        rst             = i.rst;
        bus.flush       = i.flush;
        bus.stall_ex    = i.stall_ex;
        bus.stall_mem   = i.stall_mem;
        bus.ex_wreg     = i.wreg;
        bus.ex_wd       = i.wd;
        bus.ex_wdata    = i.wdata;
        bus.ex_whilo    = i.whilo;
        bus.ex_hi       = i.hi;
        bus.ex_lo       = i.lo;
        bus.ex_hilo_tmp = i.tmp;
        bus.ex_cnt      = i.cnt;
    endtask

    task automatic check(string name, out_t e);
        out_t a;
        a = {bus.mem_wreg, bus.mem_wd, bus.mem_wdata, bus.mem_whilo, bus.mem_hi,
             bus.mem_lo, bus.mem_valid, bus.hilo_tmp_o, bus.cnt_o};
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got wreg=%0b wd=%0d wdata=%h whilo=%0b hi=%h lo=%h valid=%0b tmp=%h cnt=%b | want wreg=%0b wd=%0d wdata=%h whilo=%0b hi=%h lo=%h valid=%0b tmp=%h cnt=%b",
                     name, a.wreg, a.wd, a.wdata, a.whilo, a.hi, a.lo, a.valid, a.tmp, a.cnt,
                     e.wreg, e.wd, e.wdata, e.whilo, e.hi, e.lo, e.valid, e.tmp, e.cnt);
        end
    endtask

    task automatic apply(string name, in_t i, out_t e);
        @(negedge clk);
        drive(i);
        @(posedge clk);
        #1;
        check(name, e);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        out_t zero;
        out_t held;
        out_t st;
        in_t  ri;
        zero = '0;
        held = mk_out(1'b1, 5'd4, 32'hA5A5A5A5, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'b00);

        vecs.push_back('{"reset0", mk_in(1,0,0,0, 1,5'd3,32'hDEADBEEF,0,0,0,64'h0,2'b00), zero});
        vecs.push_back('{"reset1", mk_in(1,0,0,0, 1,5'd3,32'hDEADBEEF,0,0,0,64'h0,2'b00), zero});
        vecs.push_back('{"advance", mk_in(0,0,0,0, 1,5'd7,32'h12345678,1,32'h1,32'h2,64'h0,2'b00),
                         mk_out(1,5'd7,32'h12345678,1,32'h1,32'h2,1,64'h0,2'b00)});
        vecs.push_back('{"madd_bubble", mk_in(0,0,1,0, 1,5'd9,32'h55,0,0,0,64'h0000_0001_0000_0002,2'b01),
                         mk_out(0,0,0,0,0,0,0,64'h0000_0001_0000_0002,2'b01)});
        vecs.push_back('{"madd_complete", mk_in(0,0,0,0, 1,5'd9,32'h55,1,32'h10,32'h20,64'h0,2'b00),
                         mk_out(1,5'd9,32'h55,1,32'h10,32'h20,1,64'h0,2'b00)});
        vecs.push_back('{"load_a5", mk_in(0,0,0,0, 1,5'd4,32'hA5A5A5A5,0,0,0,64'h0,2'b00), held});
        for (int k = 0; k < 3; k++)
            vecs.push_back('{$sformatf("hold%0d", k),
                             mk_in(0,0,1,1, 0,5'd31,32'hFFFF_0000 + 32'(k),1,32'h77,32'h88,64'hFEED,2'b10), held});
        vecs.push_back('{"bubble_mul1", mk_in(0,0,1,0, 1,5'd2,32'h99,1,0,0,64'hCAFE_0000_BEEF_0001,2'b01),
                         mk_out(0,0,0,0,0,0,0,64'hCAFE_0000_BEEF_0001,2'b01)});
        vecs.push_back('{"flush_mid_madd", mk_in(0,1,1,1, 1,5'd2,32'h99,1,0,0,64'h1234,2'b01), zero});
        vecs.push_back('{"bubble_mul1b", mk_in(0,0,1,0, 0,0,0,0,0,0,64'h7,2'b01),
                         mk_out(0,0,0,0,0,0,0,64'h7,2'b01)});
        vecs.push_back('{"reset_mid_madd", mk_in(1,0,1,0, 1,5'd1,32'h1,0,0,0,64'h9,2'b01), zero});
        vecs.push_back('{"cnt10_pass", mk_in(0,0,1,0, 0,0,0,0,0,0,64'h3,2'b10),
                         mk_out(0,0,0,0,0,0,0,64'h3,2'b10)});
        vecs.push_back('{"load_before_flush", mk_in(0,0,0,0, 1,5'd12,32'h0BAD_F00D,0,0,0,64'h0,2'b00),
                         mk_out(1,5'd12,32'h0BAD_F00D,0,0,0,1,64'h0,2'b00)});
        vecs.push_back('{"flush_advance", mk_in(0,1,0,0, 1,5'd13,32'h1111,1,32'h5,32'h6,64'h0,2'b00), zero});

        foreach (vecs[n]) apply(vecs[n].name, vecs[n].i, vecs[n].e);

        // Randomized traffic; stall pair drawn from the three legal combinations.
        st = vecs[vecs.size()-1].e;
        for (int n = 0; n < 400; n++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            ri.rst       = ($urandom_range(0, 31) == 0);
            ri.flush     = ($urandom_range(0, 15) == 0);
            ri.stall_ex  = (sel != 0);
            ri.stall_mem = (sel == 2);
            ri.wreg      = 1'($urandom);
            ri.wd        = 5'($urandom);
            ri.wdata     = $urandom;
            ri.whilo     = 1'($urandom);
            ri.hi        = $urandom;
            ri.lo        = $urandom;
            ri.tmp       = {$urandom, $urandom};
            ri.cnt       = 2'($urandom);
            st = model(ri, st);
            apply($sformatf("rand%0d", n), ri, st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
